// File: rtl/alu_vec_checker.sv
// Vector checker for a combinational 8-bit ALU: drives operands, compares F to golden.
// Define ALU_CHK_FAIL_LOG_EN to capture the first mismatch of each run on fail_*.
module alu_vec_checker #(
    parameter int unsigned NUM_VEC  = 200,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        vec_valid,
    output logic        vec_ready,
    input  logic [7:0]  vec_a,
    input  logic [7:0]  vec_b,
    input  logic [3:0]  vec_instr,
    input  logic [7:0]  vec_golden,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_instr,
    input  logic [7:0]  alu_f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] vec_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] fail_idx,
    output logic [7:0]  fail_a,
    output logic [7:0]  fail_b,
    output logic [3:0]  fail_instr,
    output logic [7:0]  fail_f,
    output logic [7:0]  fail_golden
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [15:0] LastVec = 16'(NUM_VEC);
    localparam logic [3:0]  WaitLd  = 4'(WAIT_CYC);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  instr_q, instr_d;
    logic [7:0]  gold_q, gold_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [15:0] ecnt_q, ecnt_d;
    logic        pass_q, pass_d;

    logic        mismatch;
    logic        clear_run;
    logic [15:0] vcnt_inc;

    assign mismatch  = |(alu_f ^ gold_q);
    assign vcnt_inc  = vcnt_q + 16'd1;
    assign clear_run = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        instr_d = instr_q;
        gold_d  = gold_q;
        vcnt_d  = vcnt_q;
        ecnt_d  = ecnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    vcnt_d  = '0;
                    ecnt_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_FETCH: begin
                if (vec_valid) begin
                    a_d     = vec_a;
                    b_d     = vec_b;
                    instr_d = vec_instr;
                    gold_d  = vec_golden;
                    wait_d  = WaitLd;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                vcnt_d = vcnt_inc;
                // error count sticks at all-ones instead of wrapping
                if (mismatch && ecnt_q != 16'hFFFF) begin
                    ecnt_d = ecnt_q + 16'd1;
                end
                if (vcnt_inc == LastVec) begin
                    state_d = S_DONE;
                    pass_d  = (ecnt_d == 16'd0);
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            instr_q <= '0;
            gold_q  <= '0;
            vcnt_q  <= '0;
            ecnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            instr_q <= instr_d;
            gold_q  <= gold_d;
            vcnt_q  <= vcnt_d;
            ecnt_q  <= ecnt_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_ready = (state_q == S_FETCH);
    assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_instr = instr_q;
    assign vec_cnt   = vcnt_q;
    assign err_cnt   = ecnt_q;

`ifdef ALU_CHK_FAIL_LOG_EN
    logic [15:0] fidx_q;
    logic [7:0]  fa_q;
    logic [7:0]  fb_q;
    logic [3:0]  fi_q;
    logic [7:0]  ff_q;
    logic [7:0]  fg_q;
    logic        capture;

    // err_cnt never returns to zero within a run, so zero marks the first miss
    assign capture = (state_q == S_CHECK) && mismatch && (ecnt_q == 16'd0);

    always_ff @(posedge clk) begin
        if (!rst_n || clear_run) begin
            fidx_q <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
            fi_q   <= '0;
            ff_q   <= '0;
            fg_q   <= '0;
        end else if (capture) begin
            fidx_q <= vcnt_q;
            fa_q   <= a_q;
            fb_q   <= b_q;
            fi_q   <= instr_q;
            ff_q   <= alu_f;
            fg_q   <= gold_q;
        end
    end

    assign fail_idx    = fidx_q;
    assign fail_a      = fa_q;
    assign fail_b      = fb_q;
    assign fail_instr  = fi_q;
    assign fail_f      = ff_q;
    assign fail_golden = fg_q;
`else
    logic unused_clear;
    assign unused_clear = clear_run;
    assign fail_idx    = '0;
    assign fail_a      = '0;
    assign fail_b      = '0;
    assign fail_instr  = '0;
    assign fail_f      = '0;
    assign fail_golden = '0;
`endif

endmodule

// File: tb/tb_alu_vec_checker.sv
// Randomized bench for alu_vec_checker with a timeline-based reference model.
// Instance 0: NUM_VEC=4, WAIT_CYC=1; instance 1: NUM_VEC=3, WAIT_CYC=3, slow ALU.
module tb_alu_vec_checker;

    localparam int NV0 = 4;
    localparam int WC0 = 1;
    localparam int NV1 = 3;
    localparam int WC1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s [2];
    logic        vv      [2];
    logic [7:0]  va      [2];
    logic [7:0]  vb      [2];
    logic [3:0]  vi      [2];
    logic [7:0]  vg      [2];
    logic        vr      [2];
    logic [7:0]  aa      [2];
    logic [7:0]  ab      [2];
    logic [3:0]  ai      [2];
    logic [7:0]  af      [2];
    logic        bsy     [2];
    logic        dn      [2];
    logic        ps      [2];
    logic [15:0] vc      [2];
    logic [15:0] ec      [2];
    logic [15:0] fidx    [2];
    logic [7:0]  fa      [2];
    logic [7:0]  fb      [2];
    logic [3:0]  fi      [2];
    logic [7:0]  ff      [2];
    logic [7:0]  fg      [2];

    alu_vec_checker #(.NUM_VEC(NV0), .WAIT_CYC(WC0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
        .vec_valid(vv[0]), .vec_ready(vr[0]),
        .vec_a(va[0]), .vec_b(vb[0]), .vec_instr(vi[0]), .vec_golden(vg[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_instr(ai[0]), .alu_f(af[0]),
        .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
        .vec_cnt(vc[0]), .err_cnt(ec[0]),
        .fail_idx(fidx[0]), .fail_a(fa[0]), .fail_b(fb[0]),
        .fail_instr(fi[0]), .fail_f(ff[0]), .fail_golden(fg[0])
    );

    alu_vec_checker #(.NUM_VEC(NV1), .WAIT_CYC(WC1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
        .vec_valid(vv[1]), .vec_ready(vr[1]),
        .vec_a(va[1]), .vec_b(vb[1]), .vec_instr(vi[1]), .vec_golden(vg[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_instr(ai[1]), .alu_f(af[1]),
        .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
        .vec_cnt(vc[1]), .err_cnt(ec[1]),
        .fail_idx(fidx[1]), .fail_a(fa[1]), .fail_b(fb[1]),
        .fail_instr(fi[1]), .fail_f(ff[1]), .fail_golden(fg[1])
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] i);
        case (i)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return {a[6:0], 1'b0};
            4'd7:    return {1'b0, a[7:1]};
            default: return a + b + {4'd0, i};
        endcase
    endfunction

    // ALU models: fast is combinational, slow shows a result 3 cycles after operands
    bit         slow0;
    logic [7:0] pa  [2][3];
    logic [7:0] pb  [2][3];
    logic [3:0] pin [2][3];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            pa[j][0]  <= aa[j];
            pb[j][0]  <= ab[j];
            pin[j][0] <= ai[j];
            for (int s = 1; s < 3; s++) begin
                pa[j][s]  <= pa[j][s-1];
                pb[j][s]  <= pb[j][s-1];
                pin[j][s] <= pin[j][s-1];
            end
        end
    end

    assign af[0] = slow0 ? alu_fn(pa[0][2], pb[0][2], pin[0][2])
                         : alu_fn(aa[0], ab[0], ai[0]);
    assign af[1] = alu_fn(pa[1][2], pb[1][2], pin[1][2]);

    // reference model: runs as lists of handshake edges and vector outcomes
    int         cyc = 0;
    int         running [2];
    int         nrec    [2];
    int         hs      [2][16];
    logic [7:0] ra      [2][16];
    logic [7:0] rb      [2][16];
    logic [3:0] ri      [2][16];
    logic [7:0] rs      [2][16];
    logic [7:0] rg      [2][16];
    bit         rm      [2][16];
    logic [7:0] la      [2];
    logic [7:0] lb      [2];
    logic [3:0] li      [2];

    logic [7:0] sa [2][16];
    logic [7:0] sb [2][16];
    logic [3:0] si [2][16];
    logic [7:0] sg [2][16];
    int         vmode [2];

    function automatic int nv(input int j);
        return (j == 0) ? NV0 : NV1;
    endfunction

    function automatic int wc(input int j);
        return (j == 0) ? WC0 : WC1;
    endfunction

    function automatic bit slow_of(input int j);
        return (j == 1) || slow0;
    endfunction

    function automatic int comp(input int j, input int t);
        int n = 0;
        for (int k = 0; k < nrec[j]; k++)
            if (hs[j][k] + wc(j) + 1 <= t) n++;
        return n;
    endfunction

    function automatic int errs(input int j, input int t);
        int n = 0;
        for (int k = 0; k < nrec[j]; k++)
            if (rm[j][k] && hs[j][k] + wc(j) + 1 <= t) n++;
        return (n > 65535) ? 65535 : n;
    endfunction

    function automatic int first_fail(input int j, input int t);
        for (int k = 0; k < nrec[j]; k++)
            if (rm[j][k] && hs[j][k] + wc(j) + 1 <= t) return k;
        return -1;
    endfunction

    function automatic bit done_m(input int j, input int t);
        return running[j] != 0 && comp(j, t) == nv(j);
    endfunction

    function automatic bit busy_m(input int j, input int t);
        return running[j] != 0 && !done_m(j, t);
    endfunction

    function automatic bit fetch_m(input int j, input int t);
        if (!busy_m(j, t)) return 1'b0;
        if (nrec[j] == 0) return 1'b1;
        return t >= hs[j][nrec[j]-1] + wc(j) + 1;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                running[j] = 0;
                nrec[j]    = 0;
                la[j]      = '0;
                lb[j]      = '0;
                li[j]      = '0;
            end else if (start_s[j] && !busy_m(j, cyc - 1)) begin
                running[j] = 1;
                nrec[j]    = 0;
            end else if (fetch_m(j, cyc - 1) && vv[j]) begin
                int k;
                logic [7:0] seen;
                k = nrec[j];
                if (slow_of(j) && wc(j) < 3) seen = alu_fn(la[j], lb[j], li[j]);
                else seen = alu_fn(va[j], vb[j], vi[j]);
                hs[j][k] = cyc;
                ra[j][k] = va[j];
                rb[j][k] = vb[j];
                ri[j][k] = vi[j];
                rg[j][k] = vg[j];
                rs[j][k] = seen;
                rm[j][k] = (seen != vg[j]);
                la[j]    = va[j];
                lb[j]    = vb[j];
                li[j]    = vi[j];
                nrec[j]  = k + 1;
            end
        end
    end

    // vector source: presents the next unsent vector, garbage when not valid
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            int  p;
            logic v;
            p = nrec[j];
            v = (vmode[j] == 1) || (vmode[j] == 2 && $urandom_range(0, 2) != 0);
            if (v && p < nv(j)) begin
                vv[j] = 1'b1;
                va[j] = sa[j][p];
                vb[j] = sb[j][p];
                vi[j] = si[j][p];
                vg[j] = sg[j][p];
            end else begin
                vv[j] = 1'b0;
                va[j] = 8'($urandom);
                vb[j] = 8'($urandom);
                vi[j] = 4'($urandom);
                vg[j] = 8'($urandom);
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int j, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", nm, j, cyc, got, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int j = 0; j < 2; j++) begin
                int fk;
                fk = first_fail(j, cyc);
                chk("vec_ready", j, 32'(vr[j]), 32'(fetch_m(j, cyc)));
                chk("busy", j, 32'(bsy[j]), 32'(busy_m(j, cyc)));
                chk("done", j, 32'(dn[j]), 32'(done_m(j, cyc)));
                chk("pass", j, 32'(ps[j]), 32'(done_m(j, cyc) && errs(j, cyc) == 0));
                chk("vec_cnt", j, 32'(vc[j]), 32'(comp(j, cyc)));
                chk("err_cnt", j, 32'(ec[j]), 32'(errs(j, cyc)));
                chk("alu_a", j, 32'(aa[j]), 32'(la[j]));
                chk("alu_b", j, 32'(ab[j]), 32'(lb[j]));
                chk("alu_instr", j, 32'(ai[j]), 32'(li[j]));
`ifdef ALU_CHK_FAIL_LOG_EN
                if (fk >= 0) begin
                    chk("fail_idx", j, 32'(fidx[j]), 32'(fk));
                    chk("fail_a", j, 32'(fa[j]), 32'(ra[j][fk]));
                    chk("fail_b", j, 32'(fb[j]), 32'(rb[j][fk]));
                    chk("fail_instr", j, 32'(fi[j]), 32'(ri[j][fk]));
                    chk("fail_f", j, 32'(ff[j]), 32'(rs[j][fk]));
                    chk("fail_golden", j, 32'(fg[j]), 32'(rg[j][fk]));
                end else begin
                    chk("fail_rec_clr", j,
                        {fidx[j], fa[j], fb[j]} | {8'd0, fi[j], ff[j], fg[j]}, 32'd0);
                end
`else
                chk("fail_rec_zero", j,
                    {fidx[j], fa[j], fb[j]} | {8'd0, fi[j], ff[j], fg[j]}, 32'd0);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input bit s0, input bit s1);
        start_s[0] = s0;
        start_s[1] = s1;
        tick();
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
    endtask

    task automatic wait_done(input int j);
        int n = 0;
        while (!done_m(j, cyc) && n < 300) begin
            tick();
            n++;
        end
        chk("done_reached", j, 32'(dn[j]), 32'd1);
    endtask

    task automatic wait_nrec(input int j, input int cnt);
        int n = 0;
        while (nrec[j] < cnt && n < 100) begin
            tick();
            n++;
        end
        chk("handshake_seen", j, 32'(nrec[j] >= cnt), 32'd1);
    endtask

    task automatic fill_rand(input int j, input int perr);
        for (int k = 0; k < 16; k++) begin
            sa[j][k] = 8'($urandom);
            sb[j][k] = 8'($urandom);
            si[j][k] = 4'($urandom_range(0, 9));
            sg[j][k] = alu_fn(sa[j][k], sb[j][k], si[j][k]);
            if ($urandom_range(0, 99) < perr)
                sg[j][k] = sg[j][k] ^ (8'd1 << $urandom_range(0, 7));
        end
    endtask

    task automatic set_vec(input int j, input int k, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] i,
                           input logic [7:0] g);
        sa[j][k] = a;
        sb[j][k] = b;
        si[j][k] = i;
        sg[j][k] = g;
    endtask

    initial begin
        int         s;
        logic [7:0] saved_a;
        rst_n      = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        vmode[0]   = 0;
        vmode[1]   = 0;
        slow0      = 1'b0;
        for (int j = 0; j < 2; j++) begin
            running[j] = 0;
            nrec[j]    = 0;
            la[j]      = '0;
            lb[j]      = '0;
            li[j]      = '0;
        end
        fill_rand(0, 0);
        fill_rand(1, 0);
        @(posedge clk);
        chk_on = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready", 0, 32'(vr[0]), 32'd0);
        chk("rst_vec_cnt", 0, 32'(vc[0]), 32'd0);
        chk("rst_alu_a", 1, 32'(aa[1]), 32'd0);

        // four clean vectors, valid held high
        vmode[0] = 1;
        pulse(1'b1, 1'b0);
        s = cyc;
        repeat (11) tick();
        chk("done_early", 0, 32'(dn[0]), 32'd0);
        tick();
        chk("done_at_12", 0, 32'(dn[0]), 32'd1);
        chk("cnt_at_12", 0, 32'(vc[0]), 32'd4);
        chk("err_at_12", 0, 32'(ec[0]), 32'd0);
        chk("pass_at_12", 0, 32'(ps[0]), 32'd1);
        chk("t_start", 0, 32'(cyc - s), 32'd12);

        // restart from DONE, stall with valid low, then a start inside WAIT
        saved_a = sa[0][3];
        fill_rand(0, 30);
        vmode[0] = 0;
        pulse(1'b1, 1'b0);
        chk("restart_err", 0, 32'(ec[0]), 32'd0);
        repeat (5) begin
            chk("stall_ready", 0, 32'(vr[0]), 32'd1);
            chk("stall_alu_a", 0, 32'(aa[0]), 32'(saved_a));
            chk("stall_cnt", 0, 32'(vc[0]), 32'd0);
            tick();
        end
        vmode[0] = 2;
        wait_nrec(0, 1);
        pulse(1'b1, 1'b0);
        wait_done(0);
        chk("ignored_start_cnt", 0, 32'(vc[0]), 32'd4);

        // slow ALU: WAIT_CYC=1 sees stale F, WAIT_CYC=3 sees the right one
        slow0 = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        set_vec(0, 0, 8'h10, 8'h01, 4'd0, 8'h11);
        set_vec(0, 1, 8'h22, 8'h02, 4'd0, 8'h24);
        set_vec(0, 2, 8'h30, 8'h0F, 4'd2, 8'h00);
        set_vec(0, 3, 8'h0F, 8'hF0, 4'd3, 8'hFF);
        set_vec(1, 0, 8'h01, 8'h02, 4'd0, 8'h03);
        set_vec(1, 1, 8'h50, 8'h04, 4'd0, 8'h55);
        set_vec(1, 2, 8'hAA, 8'h0F, 4'd2, 8'h0A);
        vmode[0] = 1;
        vmode[1] = 1;
        pulse(1'b1, 1'b1);
        wait_done(0);
        wait_done(1);
        chk("stale_err", 0, 32'(ec[0]), 32'd4);
        chk("stale_pass", 0, 32'(ps[0]), 32'd0);
        chk("gold55_err", 1, 32'(ec[1]), 32'd1);
        chk("gold55_pass", 1, 32'(ps[1]), 32'd0);
`ifdef ALU_CHK_FAIL_LOG_EN
        chk("gold55_idx", 1, 32'(fidx[1]), 32'd1);
        chk("gold55_f", 1, 32'(ff[1]), 32'h54);
        chk("gold55_golden", 1, 32'(fg[1]), 32'h55);
`endif
        tick();
        slow0 = 1'b0;

        // reset during WAIT of the second vector
        fill_rand(0, 0);
        vmode[0] = 1;
        pulse(1'b1, 1'b0);
        wait_nrec(0, 2);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 0, 32'(bsy[0]), 32'd0);
        chk("abort_done", 0, 32'(dn[0]), 32'd0);
        chk("abort_cnt", 0, 32'(vc[0]), 32'd0);
        chk("abort_err", 0, 32'(ec[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        pulse(1'b1, 1'b0);
        wait_done(0);
        chk("rerun_cnt", 0, 32'(vc[0]), 32'd4);
        chk("rerun_pass", 0, 32'(ps[0]), 32'd1);

        // random runs on both instances
        repeat (6) begin
            fill_rand(0, 25);
            fill_rand(1, 25);
            vmode[0] = 2;
            vmode[1] = 2;
            pulse(1'b1, 1'b1);
            wait_done(0);
            wait_done(1);
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
